ov_gray_linebuf: RTL

OV_GRAY_LINEBUF -- requirements
Module: ov_gray_linebuf

---
 rtl/ov_pkg.sv | 48 ++++
 rtl/lb_ram.sv | 35 +++
 rtl/ov_gray_linebuf.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/ov_pkg.sv
// Shared definitions for the grayscale line buffer: frame geometry defaults,
// coordinate widths, FSM state encoding, luma weights and the RGB565 to gray
// conversion.
// Build option: define OV_GRAY_WEIGHTED_EN for (77R + 150G + 29B) >> 8 luma;
// otherwise the cheaper (R + 2G + B) >> 2 approximation is used.
package ov_pkg;

  localparam int unsigned ImgWDefault = 640;
  localparam int unsigned ImgHDefault = 480;

  // Coordinate widths cover the largest supported frame (1024 x 512).
  localparam int unsigned XW = 10;
  localparam int unsigned YW = 9;

  typedef enum logic [1:0] {
    StIdle,
    StActive,
    StDone
  } state_e;

  // Weights sum to 256, so the weighted result never exceeds 255.
  localparam logic [7:0] LumaWR = 8'd77;
  localparam logic [7:0] LumaWG = 8'd150;
  localparam logic [7:0] LumaWB = 8'd29;

  // Expand each channel to 8 bits by replicating its MSBs, then take luma.
  function automatic logic [7:0] rgb565_to_gray(input logic [15:0] pix);
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
`ifdef OV_GRAY_WEIGHTED_EN
    logic [15:0] acc;
`else
    logic [9:0] acc;
`endif
    r = {pix[15:11], pix[15:13]};
    g = {pix[10:5], pix[10:9]};
    b = {pix[4:0], pix[4:2]};
`ifdef OV_GRAY_WEIGHTED_EN
    acc = 16'(LumaWR) * 16'(r) + 16'(LumaWG) * 16'(g) + 16'(LumaWB) * 16'(b);
    return acc[15:8];
`else
    acc = {2'b00, r} + {1'b0, g, 1'b0} + {2'b00, b};
    return acc[9:2];
`endif
  endfunction

endpackage

// File: rtl/lb_ram.sv
// Simple dual-port 8-bit line RAM: one write port, one read port with a
// registered (one-cycle) read. Contents are deliberately not reset.
module lb_ram #(
  parameter int unsigned Depth = 640,
  parameter int unsigned AddrW = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [7:0]       wdata_i,
  input  logic             re_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [7:0]       rdata_o
);

  logic [7:0] mem_q [Depth];
  logic [7:0] rdata_q;

  // Write port.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Registered read port.
  always_ff @(posedge clk_i) begin
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/ov_gray_linebuf.sv
// Grayscale converter with a two-line buffer: for every accepted RGB565 pixel
// emits a 3-pixel vertical gray column {row y-2, row y-1, row y} two cycles
// later, together with its coordinates. Tracks frame progress and flags
// complete frames (frame_done_o) and short/aborted frames (frame_err_o).
// Build option: OV_GRAY_WEIGHTED_EN selects weighted luma (see ov_pkg).
// IMG_W must be at least 2 so a line-buffer read never meets its own write.
module ov_gray_linebuf
  import ov_pkg::*;
#(
  parameter int unsigned IMG_W = ImgWDefault,
  parameter int unsigned IMG_H = ImgHDefault
) (
  input  logic          pclk_i,
  input  logic          rst_ni,
  input  logic [15:0]   pix_data_i,
  input  logic          pix_valid_i,
  input  logic          sof_i,
  input  logic          eof_i,
  output logic [23:0]   col_o,
  output logic          col_valid_o,
  output logic [XW-1:0] x_o,
  output logic [YW-1:0] y_o,
  output logic          frame_done_o,
  output logic          frame_err_o
);

  localparam logic [XW-1:0] XLast = XW'(IMG_W - 1);
  localparam logic [YW-1:0] YLast = YW'(IMG_H - 1);
  localparam int unsigned   LbAw  = (IMG_W > 1) ? $clog2(IMG_W) : 1;

  // Frame tracking state.
  state_e        state_q;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic          eof_q;
  logic          err_q;

  // Current-pixel decode.
  logic          accept;
  logic          last_pix;
  logic          eof_rise;
  logic [XW-1:0] pix_x;
  logic [YW-1:0] pix_y;
  logic [7:0]    gray;

  // Stage 1: converted pixel waiting for the line-buffer read data.
  logic          s1_valid_q;
  logic          s1_last_q;
  logic [XW-1:0] s1_x_q;
  logic [YW-1:0] s1_y_q;
  logic [7:0]    s1_gray_q;

  // Line-buffer read data (valid in stage 1).
  logic [7:0] lb0_rdata;
  logic [7:0] lb1_rdata;

  // Output stage.
  logic [23:0]   col_q;
  logic          col_valid_q;
  logic [XW-1:0] x_out_q;
  logic [YW-1:0] y_out_q;
  logic          done_q;

  // Decide whether this cycle's pixel is taken and where the counters go next.
  always_comb begin
    pix_x    = sof_i ? '0 : x_q;
    pix_y    = sof_i ? '0 : y_q;
    accept   = pix_valid_i && (sof_i || (state_q == StActive));
    last_pix = accept && (pix_x == XLast) && (pix_y == YLast);
    eof_rise = eof_i && !eof_q;
    gray     = rgb565_to_gray(pix_data_i);
    x_d      = x_q;
    y_d      = y_q;
    if (accept) begin
      if (pix_x == XLast) begin
        x_d = '0;
        y_d = pix_y + 1'b1;
      end else begin
        x_d = pix_x + 1'b1;
        y_d = pix_y;
      end
    end else if (sof_i) begin
      x_d = '0;
      y_d = '0;
    end
  end

  // Frame FSM with pixel counters and the registered error pulse.
  always_ff @(posedge pclk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      x_q     <= '0;
      y_q     <= '0;
      eof_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      eof_q <= eof_i;
      err_q <= 1'b0;
      x_q   <= x_d;
      y_q   <= y_d;
      unique case (state_q)
        StIdle, StDone: begin
          if (sof_i) begin
            state_q <= last_pix ? StDone : StActive;
          end
        end
        StActive: begin
          if (sof_i) begin
            // Restart discards the partial frame.
            err_q   <= 1'b1;
            state_q <= last_pix ? StDone : StActive;
          end else if (last_pix) begin
            state_q <= StDone;
          end else if (eof_rise) begin
            err_q   <= 1'b1;
            state_q <= StDone;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Stage 1 register: gray value and coordinates while the RAM read completes.
  always_ff @(posedge pclk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_x_q     <= '0;
      s1_y_q     <= '0;
      s1_gray_q  <= '0;
    end else begin
      s1_valid_q <= accept;
      s1_last_q  <= last_pix;
      if (accept) begin
        s1_x_q    <= pix_x;
        s1_y_q    <= pix_y;
        s1_gray_q <= gray;
      end
    end
  end

  // LB0 holds row y-1; it takes the new gray value once the old one is read.
  lb_ram #(
    .Depth (IMG_W),
    .AddrW (LbAw)
  ) u_lb0 (
    .clk_i   (pclk_i),
    .we_i    (s1_valid_q),
    .waddr_i (s1_x_q[LbAw-1:0]),
    .wdata_i (s1_gray_q),
    .re_i    (accept),
    .raddr_i (pix_x[LbAw-1:0]),
    .rdata_o (lb0_rdata)
  );

  // LB1 holds row y-2; it receives the value displaced from LB0.
  lb_ram #(
    .Depth (IMG_W),
    .AddrW (LbAw)
  ) u_lb1 (
    .clk_i   (pclk_i),
    .we_i    (s1_valid_q),
    .waddr_i (s1_x_q[LbAw-1:0]),
    .wdata_i (lb0_rdata),
    .re_i    (accept),
    .raddr_i (pix_x[LbAw-1:0]),
    .rdata_o (lb1_rdata)
  );

  // Output register: assemble the column, masking rows above the frame top
  // (the buffers may hold stale data from a previous or aborted frame).
  always_ff @(posedge pclk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      col_q       <= '0;
      col_valid_q <= 1'b0;
      x_out_q     <= '0;
      y_out_q     <= '0;
      done_q      <= 1'b0;
    end else begin
      col_valid_q <= s1_valid_q;
      done_q      <= s1_valid_q && s1_last_q;
      if (s1_valid_q) begin
        col_q[23:16] <= (s1_y_q >= YW'(2)) ? lb1_rdata : 8'd0;
        col_q[15:8]  <= (s1_y_q >= YW'(1)) ? lb0_rdata : 8'd0;
        col_q[7:0]   <= s1_gray_q;
        x_out_q      <= s1_x_q;
        y_out_q      <= s1_y_q;
      end
    end
  end

  assign col_o        = col_q;
  assign col_valid_o  = col_valid_q;
  assign x_o          = x_out_q;
  assign y_o          = y_out_q;
  assign frame_done_o = done_q;
  assign frame_err_o  = err_q;

endmodule
